// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and related schedulers.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int STAT_W = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus FIFO write port seen by the write arbiter.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 8
);
    import fifo_arb_pkg::*;

    localparam int ID_W = clog2(N_REQ);

    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*FIFO_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        full;
    logic                        wr_en;
    logic [FIFO_WIDTH-1:0]       din;
    logic [ID_W-1:0]             gnt_id;
    logic                        busy;

    modport master (
        output req_valid, req_data, full,
        input  req_ready, wr_en, din, gnt_id, busy
    );

    modport slave (
        input  req_valid, req_data, full,
        output req_ready, wr_en, din, gnt_id, busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching last+1, last+2, ... (mod N_REQ).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [ID_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[gi] is the requester sitting gi+1 places after the last winner
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign cand[gi] = ID_W'((int'(last) + gi + 1) % N_REQ);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                idx   = cand[k];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async_fifo write port between N_REQ producers.
// Optional FIFO_WR_ARB_STATS_EN adds saturating stall_cnt / grant_cnt outputs.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic               clk,
    input  logic               rst,
    fifo_wr_arbiter_if.slave   bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]  stall_cnt,
    output logic [STAT_W-1:0]  grant_cnt
`endif
);

    localparam int ID_W  = clog2(N_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);

    arb_state_t       state_reg;
    logic [ID_W-1:0]  gnt_id_reg;
    logic [ID_W-1:0]  last_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    logic                  in_grant;
    logic                  g_valid;
    logic                  accept;
    logic                  last_word;
    logic [FIFO_WIDTH-1:0] lane [N_REQ];

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (bus.req_valid),
        .last  (last_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign in_grant  = (state_reg == ARB_GRANT);
    assign g_valid   = bus.req_valid[gnt_id_reg];
    assign accept    = in_grant & g_valid & ~bus.full;
    assign last_word = (cnt_reg == CNT_W'(MAX_BURST - 1));

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane[gi]          = bus.req_data[gi*FIFO_WIDTH +: FIFO_WIDTH];
            assign bus.req_ready[gi] = in_grant & ~bus.full & (gnt_id_reg == ID_W'(gi));
        end
    endgenerate

    // Write port is driven straight from the granted lane: no added latency
    assign bus.wr_en  = accept;
    assign bus.din    = in_grant ? lane[gnt_id_reg] : '0;
    assign bus.gnt_id = gnt_id_reg;
    assign bus.busy   = in_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ARB_IDLE;
            gnt_id_reg <= '0;
            cnt_reg    <= '0;
            last_reg   <= ID_W'(N_REQ - 1);
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick_found) begin
                        gnt_id_reg <= pick_idx;
                        cnt_reg    <= '0;
                        state_reg  <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    // A stalled cycle (full with valid) holds grant and count
                    if (!g_valid) begin
                        state_reg <= ARB_IDLE;
                        last_reg  <= gnt_id_reg;
                    end else if (accept) begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (last_word) begin
                            state_reg <= ARB_IDLE;
                            last_reg  <= gnt_id_reg;
                        end
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STAT_W-1:0] stall_cnt_reg;
    logic [STAT_W-1:0] grant_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            grant_cnt_reg <= '0;
        end else begin
            if (in_grant && g_valid && bus.full && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (state_reg == ARB_IDLE && pick_found && grant_cnt_reg != '1)
                grant_cnt_reg <= grant_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign grant_cnt = grant_cnt_reg;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: cycle table plus producer/scoreboard sequences.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;
    localparam int NV = 21;

    logic clk;
    logic rst;

    fifo_wr_arbiter_if #(.N_REQ(N), .FIFO_WIDTH(W)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] grant_cnt;
`endif

    fifo_wr_arbiter #(
        .N_REQ      (N),
        .FIFO_WIDTH (W),
        .MAX_BURST  (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt),
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic [7:0] d2;
        logic       exp_wr;
        logic [7:0] exp_din;
        logic [3:0] exp_rdy;
        logic       exp_busy;
        logic [1:0] exp_gnt;
    } vec_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    vec_t       vt [NV];
    exp_t       exp_q [$];
    logic [7:0] prod_q [N][$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_cyc;
    int last_cyc;
    int n_writes;

    function automatic vec_t mk(logic [3:0] v, logic f, logic [7:0] d, logic w,
                                logic [7:0] dn, logic [3:0] r, logic b, logic [1:0] g);
        vec_t x;
        x.valid = v; x.full = f; x.d2 = d; x.exp_wr = w;
        x.exp_din = dn; x.exp_rdy = r; x.exp_busy = b; x.exp_gnt = g;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i] = (prod_q[i].size() > 0);
            bus.req_data[i*W +: W] = (prod_q[i].size() > 0) ? prod_q[i][0] : 8'h00;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.full = 1'b0;
        for (int i = 0; i < N; i++) prod_q[i].delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: sample at negedge, retire accepted words after the edge
    task automatic step();
        logic [N-1:0] acc;
        exp_t e;
        @(negedge clk);
        cyc++;
        acc = bus.req_ready & bus.req_valid;
        check("handshake", {30'b0, bus.wr_en, $onehot0(bus.req_ready)}, {30'b0, |acc, 1'b1});
        if (bus.wr_en) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got id %0d data %0h expected no write", bus.gnt_id, bus.din);
            end else begin
                e = exp_q.pop_front();
                $display("write cyc=%0d id=%0d data=%0h", cyc, bus.gnt_id, bus.din);
                check("wr_id", 32'(bus.gnt_id), 32'(e.id));
                check("wr_data", 32'(bus.din), 32'(e.data));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        end
        drive();
    endtask

    task automatic run(int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got %0d pending writes expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with every requester asking: nothing may be granted
        rst = 1'b1;
        bus.full = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data = 32'h44332211;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        check("rst_wr_en", 32'(bus.wr_en), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle_busy", 32'(bus.busy), 32'h0);
        check("post_rst_idle_gnt", 32'(bus.gnt_id), 32'h0);
        @(negedge clk);
        check("first_grant_busy", 32'(bus.busy), 32'h1);
        check("first_grant_gnt", 32'(bus.gnt_id), 32'h0);
        check("first_grant_din", 32'(bus.din), 32'h11);
        @(posedge clk);
        #1;

        // Cycle table: requester 2 alone, two full bursts, then a 5-cycle full stall
        vt[0] = mk(4'b0100, 1'b0, 8'h10, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd0);
        for (int k = 1; k <= 4; k++)
            vt[k] = mk(4'b0100, 1'b0, 8'(8'h0F + k), 1'b1, 8'(8'h0F + k), 4'b0100, 1'b1, 2'd2);
        vt[5] = mk(4'b0100, 1'b0, 8'h14, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);
        for (int k = 6; k <= 9; k++)
            vt[k] = mk(4'b0100, 1'b0, 8'(8'h0E + k), 1'b1, 8'(8'h0E + k), 4'b0100, 1'b1, 2'd2);
        vt[10] = mk(4'b0100, 1'b0, 8'h18, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);
        vt[11] = mk(4'b0100, 1'b0, 8'h18, 1'b1, 8'h18, 4'b0100, 1'b1, 2'd2);
        vt[12] = mk(4'b0100, 1'b0, 8'h19, 1'b1, 8'h19, 4'b0100, 1'b1, 2'd2);
        for (int k = 13; k <= 17; k++)
            vt[k] = mk(4'b0100, 1'b1, 8'h1A, 1'b0, 8'h1A, 4'b0000, 1'b1, 2'd2);
        vt[18] = mk(4'b0100, 1'b0, 8'h1A, 1'b1, 8'h1A, 4'b0100, 1'b1, 2'd2);
        vt[19] = mk(4'b0100, 1'b0, 8'h1B, 1'b1, 8'h1B, 4'b0100, 1'b1, 2'd2);
        vt[20] = mk(4'b0000, 1'b0, 8'h00, 1'b0, 8'h00, 4'b0000, 1'b0, 2'd2);

        do_reset();
        for (int k = 0; k < NV; k++) begin
            bus.req_valid = vt[k].valid;
            bus.full      = vt[k].full;
            bus.req_data  = {8'hA3, vt[k].d2, 8'hA1, 8'hA0};
            @(negedge clk);
            cyc++;
            $display("vec %0d wr_en=%0b din=%0h ready=%0b busy=%0b gnt=%0d",
                     k, bus.wr_en, bus.din, bus.req_ready, bus.busy, bus.gnt_id);
            check($sformatf("vec%0d_wr_en", k), 32'(bus.wr_en), 32'(vt[k].exp_wr));
            check($sformatf("vec%0d_din", k), 32'(bus.din), 32'(vt[k].exp_din));
            check($sformatf("vec%0d_ready", k), 32'(bus.req_ready), 32'(vt[k].exp_rdy));
            check($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(vt[k].exp_busy));
            check($sformatf("vec%0d_gnt", k), 32'(bus.gnt_id), 32'(vt[k].exp_gnt));
            @(posedge clk);
            #1;
        end
`ifdef FIFO_WR_ARB_STATS_EN
        check("stall_cnt", 32'(stall_cnt), 32'd5);
        check("grant_cnt", 32'(grant_cnt), 32'd3);
`endif

        // Round robin: all requesters busy, grant order 0,1,2,3,0
        do_reset();
        for (int k = 0; k < 8; k++) prod_q[0].push_back(8'(k));
        for (int i = 1; i < N; i++)
            for (int k = 0; k < MB; k++) prod_q[i].push_back(8'(i * 16 + k));
        for (int k = 0; k < MB; k++) exp_q.push_back('{id: 2'd0, data: 8'(k)});
        for (int i = 1; i < N; i++)
            for (int k = 0; k < MB; k++) exp_q.push_back('{id: 2'(i), data: 8'(i * 16 + k)});
        for (int k = 4; k < 8; k++) exp_q.push_back('{id: 2'd0, data: 8'(k)});
        drive();
        first_cyc = -1;
        run(200);
        check("rr_span", 32'(last_cyc - first_cyc + 1), 32'd24);

        // Early end: requester 1 offers only 2 words, then requester 2 takes over
        do_reset();
        prod_q[1].push_back(8'h51);
        prod_q[1].push_back(8'h52);
        for (int k = 0; k < 4; k++) prod_q[2].push_back(8'(8'h61 + k));
        exp_q.push_back('{id: 2'd1, data: 8'h51});
        exp_q.push_back('{id: 2'd1, data: 8'h52});
        for (int k = 0; k < 4; k++) exp_q.push_back('{id: 2'd2, data: 8'(8'h61 + k)});
        drive();
        first_cyc = -1;
        run(100);
        check("early_span", 32'(last_cyc - first_cyc + 1), 32'd8);

        // Reset between edges after the first word of a burst
        do_reset();
        for (int k = 0; k < 4; k++) prod_q[3].push_back(8'(8'h30 + k));
        exp_q.push_back('{id: 2'd3, data: 8'h30});
        drive();
        first_cyc = -1;
        n_writes = 0;
        for (int n = 0; n < 10 && exp_q.size() > 0; n++) step();
        check("mid_pending", 32'(exp_q.size()), 32'd0);
        check("mid_words_before_rst", 32'(n_writes), 32'd1);
        check("mid_wr_en_before_rst", 32'(bus.wr_en), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        exp_q.delete();
        prod_q[0].push_back(8'h01);
        prod_q[0].push_back(8'h02);
        exp_q.push_back('{id: 2'd0, data: 8'h01});
        exp_q.push_back('{id: 2'd0, data: 8'h02});
        for (int k = 1; k < 4; k++) exp_q.push_back('{id: 2'd3, data: 8'(8'h30 + k)});
        drive();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
